tile_cfg_arbiter: RTL

//  Round-robin scheduler that shares the CGRA tile configuration write bus among NUM_REQ requesters.

---
 rtl/tile_cfg_arbiter_pkg.sv | 17 +
 rtl/tile_cfg_arbiter_if.sv | 34 +++
 rtl/tile_cfg_arbiter_rr_arbiter.sv | 28 ++
 rtl/tile_cfg_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tile_cfg_arbiter_pkg.sv
// rtl/tile_cfg_arbiter_pkg.sv - shared constants, state encodings and id check for the tile config arbiter
package tile_cfg_arbiter_pkg;

  localparam int CFG_ID_W    = 8;
  localparam int RSV_TILE_ID = 0;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Id 0 is reserved so an unprogrammed source can never hit a real tile.
  function automatic logic tile_id_legal(input logic [31:0] id, input logic [31:0] max_id);
    return (id != 32'(RSV_TILE_ID)) && (id <= max_id);
  endfunction

endpackage

// File: rtl/tile_cfg_arbiter_if.sv
// rtl/tile_cfg_arbiter_if.sv - requester, tile config write and response signals of the arbiter
interface tile_cfg_arbiter_if
  import tile_cfg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = CFG_ID_W,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ID_W-1:0]    req_id;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       cfg_wr;
  logic [ID_W-1:0]            cfg_id;
  logic [DATA_W-1:0]          cfg_data;
  logic                       cfg_ack;
  logic                       rsp_valid;
  logic [$clog2(NUM_REQ)-1:0] rsp_src;
  logic                       rsp_err;
  logic                       busy;

  // master: the arbiter itself; slave: config sources plus tile array
  modport master (
    input  req_valid, req_id, req_data, cfg_ack,
    output req_ready, cfg_wr, cfg_id, cfg_data, rsp_valid, rsp_src, rsp_err, busy
  );

  modport slave (
    output req_valid, req_id, req_data, cfg_ack,
    input  req_ready, cfg_wr, cfg_id, cfg_data, rsp_valid, rsp_src, rsp_err, busy
  );

endinterface

// File: rtl/tile_cfg_arbiter_rr_arbiter.sv
// rtl/tile_cfg_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import tile_cfg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
    gnt_oh = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/tile_cfg_arbiter.sv
// rtl/tile_cfg_arbiter.sv - round-robin scheduler for the CGRA tile configuration write bus
module tile_cfg_arbiter
  import tile_cfg_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = CFG_ID_W,
  parameter int DATA_W      = 32,
  parameter int MAX_TILE_ID = 15,
  parameter int TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               rst,
  tile_cfg_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q,     state_d;
  logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [IDX_W-1:0]  rsp_src_q,   rsp_src_d;
  logic [ID_W-1:0]   cfg_id_q,    cfg_id_d;
  logic [DATA_W-1:0] cfg_data_q,  cfg_data_d;
  logic              cfg_wr_q,    cfg_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              busy_q,      busy_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [ID_W-1:0]    sel_id;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_legal;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any   = |gnt_oh;
  assign sel_id    = bus.req_id[int'(gnt_idx)*ID_W +: ID_W];
  assign sel_data  = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_legal = tile_id_legal(32'(sel_id), 32'(MAX_TILE_ID));

  // Only the accept pulse is combinational; it is held off while reset is applied.
  assign bus.req_ready = (state_q == ST_IDLE && !rst) ? gnt_oh : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    rsp_src_d   = rsp_src_q;
    cfg_id_d    = cfg_id_q;
    cfg_data_d  = cfg_data_q;
    rsp_err_d   = rsp_err_q;
    cfg_wr_d    = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          rsp_src_d = gnt_idx;
          if (sel_legal) begin
            cfg_id_d   = sel_id;
            cfg_data_d = sel_data;
            cfg_wr_d   = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.cfg_ack) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (rsp_src_q == IDX_W'(NUM_REQ - 1)) ? '0 : rsp_src_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_src_q   <= '0;
      cfg_id_q    <= '0;
      cfg_data_q  <= '0;
      cfg_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      rsp_src_q   <= rsp_src_d;
      cfg_id_q    <= cfg_id_d;
      cfg_data_q  <= cfg_data_d;
      cfg_wr_q    <= cfg_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_wr    = cfg_wr_q;
  assign bus.cfg_id    = cfg_id_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule
